// File: rtl/decoder_seq_n.sv
// Registered N-to-2^N one-hot decoder whose index can be loaded, then stepped up/down.
// Optional DECODER_SEQ_ONEHOT_CHECK_EN: stored Y register plus a sticky one-hot error flag (err).
module decoder_seq_n #(
  parameter int N    = 3,
  parameter bit WRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic              load,
  input  logic [N-1:0]      sel,
  input  logic              step,
  input  logic              dir,
  output logic [2**N-1:0]   Y,
  output logic [N-1:0]      idx,
  output logic              valid,
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
  output logic              wrap,
  output logic              err
`else
  output logic              wrap
`endif
);

  localparam int OUTS = 2**N;

  logic [N-1:0] idx_nxt;
  logic         valid_nxt;
  logic         wrap_nxt;
  logic         at_top;
  logic         at_bot;
  logic         end_step;

  assign at_top   = (idx == {N{1'b1}});
  assign at_bot   = (idx == '0);
  assign end_step = dir ? at_top : at_bot;

  // With WRAP=0 an end-of-range step is rejected but still flagged on wrap.
  always_comb begin
    idx_nxt   = idx;
    valid_nxt = valid;
    wrap_nxt  = 1'b0;
    if (En) begin
      if (load) begin
        idx_nxt   = sel;
        valid_nxt = 1'b1;
      end else if (step && valid) begin
        wrap_nxt = end_step;
        if (!end_step || WRAP)
          idx_nxt = dir ? idx + N'(1) : idx - N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      idx   <= idx_nxt;
      valid <= valid_nxt;
      wrap  <= wrap_nxt;
    end
  end

`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
  logic [OUTS-1:0] y_reg;
  logic            y_multi;
  logic            y_zero;

  assign y_multi = ((y_reg & (y_reg - OUTS'(1))) != '0);
  assign y_zero  = (y_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg <= '0;
      err   <= 1'b0;
    end else begin
      if (En)
        y_reg <= valid_nxt ? (OUTS'(1) << idx_nxt) : '0;
      if (y_multi || (y_zero && valid))
        err <= 1'b1;
    end
  end

  assign Y = (En && valid) ? y_reg : '0;
`else
  assign Y = (En && valid) ? (OUTS'(1) << idx) : '0;
`endif

endmodule

// File: tb/tb_decoder_seq_n.sv
// Directed bench for decoder_seq_n: one wrapping instance and one saturating instance share stimulus.
module tb_decoder_seq_n;

  logic       clk = 1'b0;
  logic       rst, En, load, step, dir;
  logic [2:0] sel;
  logic [7:0] y_w, y_s;
  logic [2:0] idx_w, idx_s;
  logic       valid_w, valid_s, wrap_w, wrap_s;
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
  logic       err_w, err_s;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_seq_n #(.N(3), .WRAP(1'b1)) u_w (
    .clk(clk), .rst(rst), .En(En), .load(load), .sel(sel), .step(step), .dir(dir),
    .Y(y_w), .idx(idx_w), .valid(valid_w),
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
    .wrap(wrap_w), .err(err_w)
`else
    .wrap(wrap_w)
`endif
  );

  decoder_seq_n #(.N(3), .WRAP(1'b0)) u_s (
    .clk(clk), .rst(rst), .En(En), .load(load), .sel(sel), .step(step), .dir(dir),
    .Y(y_s), .idx(idx_s), .valid(valid_s),
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
    .wrap(wrap_s), .err(err_s)
`else
    .wrap(wrap_s)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Packed view for compact comparisons: {idx, valid, wrap, Y}
  task automatic test_reset();
    rst = 1'b1; En = 1'b0; load = 1'b0; step = 1'b0; dir = 1'b0; sel = 3'd0;
    cyc(); cyc();
    total++;
    if ({idx_w, valid_w, wrap_w, y_w} !== 13'h0) begin
      bad++; $display("FAIL reset_w got=%h exp=%h", {idx_w, valid_w, wrap_w, y_w}, 13'h0);
    end
    total++;
    if ({idx_s, valid_s, wrap_s, y_s} !== 13'h0) begin
      bad++; $display("FAIL reset_s got=%h exp=%h", {idx_s, valid_s, wrap_s, y_s}, 13'h0);
    end
    rst = 1'b0; En = 1'b0; load = 1'b1; sel = 3'd5;
    cyc();
    total++;
    if ({valid_w, y_w} !== 9'h000) begin
      bad++; $display("FAIL load_disabled got=%h exp=%h", {valid_w, y_w}, 9'h000);
    end
    En = 1'b1;
    cyc();
    total++;
    if ({idx_w, valid_w, y_w} !== {3'd5, 1'b1, 8'h20}) begin
      bad++; $display("FAIL load5 got=%h exp=%h", {idx_w, valid_w, y_w}, {3'd5, 1'b1, 8'h20});
    end
    load = 1'b0;
  endtask

  task automatic test_sweep();
    logic [7:0] exp_y [8];
    exp_y = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    En = 1'b1; load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      cyc();
      total++;
      if ({idx_w, y_w, y_s} !== {3'(i), exp_y[i], exp_y[i]}) begin
        bad++; $display("FAIL sweep%0d got=%h exp=%h", i, {idx_w, y_w, y_s}, {3'(i), exp_y[i], exp_y[i]});
      end
    end
    load = 1'b0;
    En = 1'b0;
    #1;
    total++;
    if ({idx_w, valid_w, y_w} !== {3'd7, 1'b1, 8'h00}) begin
      bad++; $display("FAIL en_drop got=%h exp=%h", {idx_w, valid_w, y_w}, {3'd7, 1'b1, 8'h00});
    end
    En = 1'b1;
    #1;
    total++;
    if (y_w !== 8'h80) begin
      bad++; $display("FAIL en_restore got=%h exp=%h", y_w, 8'h80);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] e_idx [3];
    logic [7:0] e_y   [3];
    logic       e_wr  [3];
    e_idx = '{3'd7, 3'd0, 3'd1};
    e_y   = '{8'h80, 8'h01, 8'h02};
    e_wr  = '{1'b0, 1'b1, 1'b0};
    load = 1'b1; sel = 3'd6;
    cyc();
    load = 1'b0; step = 1'b1; dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({idx_w, y_w, wrap_w} !== {e_idx[i], e_y[i], e_wr[i]}) begin
        bad++; $display("FAIL wrap_up%0d got=%h exp=%h", i, {idx_w, y_w, wrap_w}, {e_idx[i], e_y[i], e_wr[i]});
      end
    end
    step = 1'b0; load = 1'b1; sel = 3'd0;
    cyc();
    load = 1'b0; step = 1'b1; dir = 1'b0;
    cyc();
    total++;
    if ({idx_w, y_w, wrap_w} !== {3'd7, 8'h80, 1'b1}) begin
      bad++; $display("FAIL wrap_down got=%h exp=%h", {idx_w, y_w, wrap_w}, {3'd7, 8'h80, 1'b1});
    end
    total++;
    if ({idx_s, wrap_s} !== {3'd0, 1'b1}) begin
      bad++; $display("FAIL sat_bottom got=%h exp=%h", {idx_s, wrap_s}, {3'd0, 1'b1});
    end
    step = 1'b0;
    cyc();
    total++;
    if ({wrap_w, wrap_s} !== 2'b00) begin
      bad++; $display("FAIL wrap_clear got=%b exp=%b", {wrap_w, wrap_s}, 2'b00);
    end
  endtask

  task automatic test_saturate();
    load = 1'b1; sel = 3'd7;
    cyc();
    load = 1'b0; step = 1'b1; dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if ({idx_s, y_s, wrap_s} !== {3'd7, 8'h80, 1'b1}) begin
        bad++; $display("FAIL sat_up%0d got=%h exp=%h", i, {idx_s, y_s, wrap_s}, {3'd7, 8'h80, 1'b1});
      end
    end
    dir = 1'b0;
    cyc();
    total++;
    if ({idx_s, y_s, wrap_s} !== {3'd6, 8'h40, 1'b0}) begin
      bad++; $display("FAIL sat_down got=%h exp=%h", {idx_s, y_s, wrap_s}, {3'd6, 8'h40, 1'b0});
    end
    step = 1'b0;
  endtask

  task automatic test_enable_hold();
    load = 1'b1; sel = 3'd3;
    cyc();
    load = 1'b0; En = 1'b0; step = 1'b1; dir = 1'b1;
    cyc();
    total++;
    if ({idx_w, wrap_w, y_w} !== {3'd3, 1'b0, 8'h00}) begin
      bad++; $display("FAIL en_hold got=%h exp=%h", {idx_w, wrap_w, y_w}, {3'd3, 1'b0, 8'h00});
    end
    step = 1'b0; En = 1'b1;
    #1;
    total++;
    if (y_w !== 8'h08) begin
      bad++; $display("FAIL en_hold_y got=%h exp=%h", y_w, 8'h08);
    end
  endtask

  task automatic test_priority();
    load = 1'b1; sel = 3'd2; step = 1'b1; dir = 1'b1;
    cyc();
    total++;
    if ({idx_w, y_w, wrap_w} !== {3'd2, 8'h04, 1'b0}) begin
      bad++; $display("FAIL load_over_step got=%h exp=%h", {idx_w, y_w, wrap_w}, {3'd2, 8'h04, 1'b0});
    end
    rst = 1'b1; load = 1'b1; sel = 3'd4; step = 1'b0;
    cyc();
    total++;
    if ({idx_w, valid_w, y_w} !== {3'd0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL rst_over_load got=%h exp=%h", {idx_w, valid_w, y_w}, {3'd0, 1'b0, 8'h00});
    end
    rst = 1'b0; load = 1'b0; step = 1'b1; dir = 1'b0;
    cyc();
    total++;
    if ({idx_w, valid_w, wrap_w, y_w, idx_s, wrap_s} !== 17'h0) begin
      bad++; $display("FAIL step_invalid got=%h exp=%h", {idx_w, valid_w, wrap_w, y_w, idx_s, wrap_s}, 17'h0);
    end
    step = 1'b0;
  endtask

`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
  task automatic test_onehot_check();
    logic e;
    e = 1'b0;
    load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      cyc();
      e = e | err_w | err_s;
    end
    load = 1'b0;
    total++;
    if (e !== 1'b0) begin
      bad++; $display("FAIL err_clean got=%b exp=%b", e, 1'b0);
    end
    force u_w.y_reg = 8'h11;
    cyc();
    total++;
    if (err_w !== 1'b1) begin
      bad++; $display("FAIL err_set got=%b exp=%b", err_w, 1'b1);
    end
    release u_w.y_reg;
    load = 1'b1; sel = 3'd1;
    cyc(); cyc();
    load = 1'b0;
    total++;
    if ({err_w, err_s} !== 2'b10) begin
      bad++; $display("FAIL err_sticky got=%b exp=%b", {err_w, err_s}, 2'b10);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if (err_w !== 1'b0) begin
      bad++; $display("FAIL err_rst got=%b exp=%b", err_w, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_wrap();
    test_saturate();
    test_enable_hold();
    test_priority();
`ifdef DECODER_SEQ_ONEHOT_CHECK_EN
    test_onehot_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_seq_n.md
Name: decoder_seq_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with built-in sequencing.
- Next generation of the ALU 3-to-8 decoder: the select is captured into a register and can then be stepped up or down.
- One-hot output drives ALU function-unit and register-file write selects, including round-robin and multi-cycle operand-select sequences.
- Default N=3 gives the classic 3-to-8 behaviour, with one cycle of latency.

Parameters:
- N, 3, select width; output width OUTS = 2**N (derived, not overridable).
- WRAP, 1, 1 = index wraps at ends when stepped; 0 = index saturates at ends.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- En  input  1  enable; gates output and all state updates.
- load  input  1  capture sel into index register.
- sel  input  N  select value to load.
- step  input  1  advance index by one position.
- dir  input  1  step direction: 1 = up (+1), 0 = down (-1).
- Y  output  OUTS  one-hot decoded output, bit idx set.
- idx  output  N  current registered index.
- valid  output  1  index holds a loaded value.
- wrap  output  1  one-cycle pulse on end-of-range step.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: idx=0, valid=0, wrap=0, Y=0.
- Reset priority: rst has priority over everything, including a cycle in which load or step is asserted. Reset mid-sequence clears valid, so Y=0 the next cycle.
- Output decode: Y = (En && valid) ? (1 << idx) : 0. This is combinational from registered idx/valid and En.
  - Deasserting En zeroes Y in the same cycle without losing state.
  - Reasserting En restores the previous one-hot value.
- State updates happen only when En=1. With En=0, load and step are ignored and wrap=0.
- Update priority per rising edge (En=1): rst > load > step > hold.
- Load:
  - idx <= sel, valid <= 1, wrap <= 0.
  - Y shows 1<<sel on the cycle after load (latency 1).
  - If load and step are asserted together, load wins and the step is discarded.
- Step with valid=1:
  - dir=1: idx <= idx+1. dir=0: idx <= idx-1.
  - Arithmetic is modulo 2^N within N bits.
- End of range, WRAP=1:
  - Stepping up from OUTS-1 gives idx=0; stepping down from 0 gives idx=OUTS-1.
  - wrap=1 for exactly the following cycle.
- End of range, WRAP=0:
  - Stepping past either end leaves idx unchanged (saturate).
  - wrap=1 for exactly the following cycle, flagging the rejected step.
- Step with valid=0: ignored; idx stays 0, Y stays 0, wrap=0.
- wrap is a registered single-cycle pulse. It is cleared on any cycle without an end-of-range step.
  - Consecutive end-of-range steps (WRAP=0, held step at the end) keep wrap high on each cycle.
- Idle state: Y=0 while valid=0. After the first load, the block stays in the loaded state until rst.
- Invariant: Y is always all-zero or exactly one-hot.

Optional Feature:
- Macro: DECODER_SEQ_ONEHOT_CHECK_EN.
- When defined:
  - Y is additionally held in a dedicated OUTS-bit register, updated alongside idx.
  - Extra output port err (output, 1 bit, reset 0) is added.
  - err is a sticky flag. It sets the cycle after the stored Y register has more than one bit set, or is zero while valid=1.
  - err clears only on rst.
  - A force/deposit on the Y register must drive err high on the next edge.
- When undefined: no Y register, no err port; Y is decoded purely from idx as above.

Test Plan:
- Reset and enable, N=3: assert rst 2 cycles, then En=0, load=1, sel=5 -> Y=0x00, valid=0. Then En=1, load=1, sel=5 -> next cycle idx=5, Y=0x20, valid=1.
- Full decode sweep: load sel=0..7 on consecutive cycles with En=1 -> Y=0x01,0x02,...,0x80, each one cycle after its load. Dropping En mid-sweep -> Y=0x00 that cycle, idx unchanged.
- Wrap, WRAP=1: load 6, then step dir=1 x3 -> idx 7,0,1; Y 0x80,0x01,0x02; wrap high only the cycle idx becomes 0. Load 0, step dir=0 -> idx=7, wrap=1.
- Saturate, WRAP=0: load 7, step dir=1 held 3 cycles -> idx stays 7, Y=0x80, wrap=1 for 3 cycles. Then step dir=0 -> idx=6, wrap=0.
- Priority and reset: load=1 sel=2 and step=1 dir=1 together -> idx=2, not 3. rst asserted together with load=1 sel=4 -> idx=0, valid=0, Y=0. Step with valid=0 -> no change.
- With DECODER_SEQ_ONEHOT_CHECK_EN: normal sweep -> err=0 throughout. Deposit Y register=0x11 -> err=1 next cycle, stays 1 until rst.
